// File: rtl/mixcolumns_sequencer_if.sv
// Valid/ready handshake bundle for the MixColumns sequencer: state in, mixed state out.
// The master drives in_* and out_ready; the slave (the sequencer) drives the rest.
interface mixcolumns_sequencer_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         in_bypass;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;

   modport master (
      output in_valid, in_state, in_bypass, out_ready,
      input  in_ready, out_valid, out_state
   );

   modport slave (
      input  in_valid, in_state, in_bypass, out_ready,
      output in_ready, out_valid, out_state
   );
endinterface

// File: rtl/mixcolumns_sequencer.sv
// AES MixColumns over a 128-bit state, one 32-bit column per cycle through one shared
// MixColumn combinational block; per-block bypass for the final round.
module mixcolumns_sequencer (
   input  logic                   clk,
   input  logic                   rst_n,
   mixcolumns_sequencer_if.slave  bus,
   output logic                   busy
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StMix  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [1:0]       col_q, col_d;
   // Packed index 3 holds column 0 (MSBs), so column c lives at index ~c.
   logic [3:0][31:0] work_q, work_d;
   logic [3:0][31:0] res_q, res_d;
   logic [31:0]      mix_in, mix_out;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Shared MixColumn block: row-0 byte in the MSB of the column.
   always_comb begin
      logic [7:0] a0, a1, a2, a3;
      a0 = mix_in[31:24];
      a1 = mix_in[23:16];
      a2 = mix_in[15:8];
      a3 = mix_in[7:0];
      mix_out[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mix_out[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mix_out[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mix_out[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   end

   assign mix_in = work_q[~col_q];

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      work_d  = work_q;
      res_d   = res_q;
      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               work_d = bus.in_state;
               col_d  = 2'd0;
               if (bus.in_bypass) begin
                  res_d   = bus.in_state;
                  state_d = StDone;
               end else begin
                  state_d = StMix;
               end
            end
         end
         StMix: begin
            res_d[~col_q] = mix_out;
            col_d         = col_q + 2'd1;
            if (col_q == 2'd3) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         col_q   <= 2'd0;
         work_q  <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         work_q  <= work_d;
         res_q   <= res_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.out_state = res_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_mixcolumns_sequencer.sv
// Scoreboard bench for mixcolumns_sequencer: driver pushes expected results, a negedge
// monitor pops and compares on every output handshake and tracks latency and handshake rules.
module tb_mixcolumns_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;

   mixcolumns_sequencer_if bus_if ();

   mixcolumns_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] data;
      int           lat;
      int           acc_edge;
   } exp_t;

   exp_t         sb[$];
   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   bit           inflight = 1'b0;
   bit           rand_ready = 1'b0;
   logic         prev_valid = 1'b0;
   logic         prev_hs = 1'b0;
   logic [127:0] prev_state = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check_vec(input string name, input logic [127:0] act,
                                     input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endfunction

   function automatic void check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Reference: GF(2^8) multiply by shift-and-add, then the MixColumns matrix product.
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] a;
      p = 8'h00;
      a = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [127:0] model_mix(input logic [127:0] s);
      logic [7:0]   coef[4];
      logic [7:0]   acc;
      logic [127:0] r;
      coef = '{8'd2, 8'd3, 8'd1, 8'd1};
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
               acc = acc ^ gmul(coef[(j - row + 4) % 4], s[127 - 32*c - 8*j -: 8]);
            end
            r[127 - 32*c - 8*row -: 8] = acc;
         end
      end
      return r;
   endfunction

   // Monitor: handshake rules, latency, stability and data via the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
         inflight   = 1'b0;
      end else begin
         check_bit("busy", busy, inflight);
         check_bit("in_ready", bus_if.in_ready, !inflight);
         if (prev_valid && !prev_hs) begin
            check_bit("out_valid_hold", bus_if.out_valid, 1'b1);
            if (bus_if.out_valid) check_vec("out_state_stable", bus_if.out_state, prev_state);
         end
         if (bus_if.out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected none", bus_if.out_state);
            end else begin
               check_int("latency", cyc - sb[0].acc_edge + 1, sb[0].lat);
            end
         end
         if (bus_if.out_valid && bus_if.out_ready) begin
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               check_vec("out_state", bus_if.out_state, e.data);
            end
            inflight = 1'b0;
         end
         if (bus_if.in_valid && bus_if.in_ready) inflight = 1'b1;
         prev_valid = bus_if.out_valid;
         prev_hs    = bus_if.out_valid && bus_if.out_ready;
         prev_state = bus_if.out_state;
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         bus_if.out_ready = 1'($urandom_range(0, 1));
      end
   end

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called at posedge+1; returns at posedge+1 just after the accept edge.
   task automatic send(input logic [127:0] s, input logic byp, input logic [127:0] exp,
                       input bit keep, output int acc);
      int n;
      n = 0;
      acc = 0;
      bus_if.in_valid  = 1'b1;
      bus_if.in_state  = s;
      bus_if.in_bypass = byp;
      @(negedge clk);
      while (!bus_if.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus_if.in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
      end else begin
         acc = cyc + 1;
         sb.push_back('{exp, (byp ? 1 : 5), cyc + 1});
      end
      @(posedge clk);
      #1;
      if (!keep) bus_if.in_valid = 1'b0;
      bus_if.in_state  = rand128();
      bus_if.in_bypass = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || inflight) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
   endtask

   localparam logic [127:0] Vec1 = 128'h6347A2F0_F20A225C_01010101_C6C6C6C6;
   localparam logic [127:0] Exp1 = 128'h5DE070BB_9FDC589D_01010101_C6C6C6C6;
   localparam logic [127:0] Fips = 128'hD4BF5D30_E0B452AE_B84111F1_1E2798E5;
   localparam logic [127:0] ExpF = 128'h046681E5_E0CB199A_48F8D37A_2806264C;
   localparam logic [127:0] Byp  = 128'hD4D4D4D5_2D26314C_00000000_FFFFFFFF;

   initial begin
      int a1, a2, n;
      logic [127:0] s;
      logic         b;
      bus_if.in_valid  = 1'b0;
      bus_if.in_state  = '0;
      bus_if.in_bypass = 1'b0;
      bus_if.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check_bit("rst_in_ready", bus_if.in_ready, 1'b1);
      check_bit("rst_out_valid", bus_if.out_valid, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check_vec("rst_out_state", bus_if.out_state, 128'h0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      send(Vec1, 1'b0, Exp1, 1'b0, a1);
      drain();
      send(Fips, 1'b0, ExpF, 1'b0, a1);
      drain();
      send(Byp, 1'b1, Byp, 1'b0, a1);
      drain();

      // Backpressure with in_valid pulses during the stall.
      bus_if.out_ready = 1'b0;
      send(Vec1, 1'b0, Exp1, 1'b0, a1);
      n = 0;
      while (!bus_if.out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_bit("stall_out_valid", bus_if.out_valid, 1'b1);
      repeat (10) begin
         @(posedge clk);
         #1;
         bus_if.in_valid = 1'($urandom_range(0, 1));
         bus_if.in_state = rand128();
      end
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      drain();

      // Asynchronous reset two edges into MIX.
      send(Vec1, 1'b0, Exp1, 1'b0, a1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_bit("arst_out_valid", bus_if.out_valid, 1'b0);
      check_vec("arst_out_state", bus_if.out_state, 128'h0);
      check_bit("arst_in_ready", bus_if.in_ready, 1'b1);
      sb.delete();
      inflight = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send({32'hD4D4D4D5, 96'h0}, 1'b0, {32'hD5D5D7D6, 96'h0}, 1'b0, a1);
      drain();

      // Back-to-back with in_valid held high.
      send(Fips, 1'b0, ExpF, 1'b1, a1);
      send(Vec1, 1'b0, Exp1, 1'b0, a2);
      check_int("b2b_spacing", a2 - a1, 6);
      drain();

      // Randomised blocks with random downstream backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         s = rand128();
         b = ($urandom_range(0, 3) == 0);
         send(s, b, b ? s : model_mix(s), 1'b0, a1);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      drain();
      rand_ready = 1'b0;
      @(posedge clk);
      #2 bus_if.out_ready = 1'b1;
      repeat (3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
